// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH) + 1;

  // Iteration counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// WIDTH x WIDTH multi-cycle shift-and-add multiplier, optional two's-complement
// mode via sign-magnitude; START/BUSY/DONE handshake, product held until next result.
//
// state | meaning
// IDLE  | waiting for START, operands captured on the START edge
// CALC  | one add/shift iteration per cycle, WIDTH cycles
// FIN   | DONE pulse for one cycle, product already on MULT_SAIDA
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 SIGNED_MODE,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2*WIDTH-1:0]   MULT_SAIDA
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  mcand_q, mplier_q;
  logic              neg_q;
  logic [PW-1:0]     acc_q;

  logic              use_signed;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              neg_in;
  logic [PW-1:0]     partial, acc_next;
  logic              last_iter;

  // Magnitudes are unsigned WIDTH-bit, so the most negative value maps cleanly.
  always_comb begin
    use_signed = SIGNED_EN && SIGNED_MODE;
    a_mag      = (use_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    b_mag      = (use_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    neg_in     = use_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
    partial    = mplier_q[0] ? (PW'(mcand_q) << cnt_q) : '0;
    acc_next   = acc_q + partial;
    last_iter  = (cnt_q == LAST_CNT);
  end

  always_comb begin
    state_d = state_q;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      IDLE: if (START) state_d = CALC;
      CALC: begin
        BUSY = 1'b1;
        if (last_iter) state_d = FIN;
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      MULT_SAIDA <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (START) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            neg_q    <= neg_in;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          acc_q    <= acc_next;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_iter) MULT_SAIDA <= neg_q ? (~acc_next + 1'b1) : acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench: stimulus pushes reference products, negedge monitors pop on DONE.
module tb_shift_add_multiplier;

  localparam int W8 = 8;
  localparam int W4 = 4;

  typedef struct {
    logic [2*W8-1:0] prod;
    int              start_cyc;
  } exp8_t;

  typedef struct {
    logic [2*W4-1:0] prod;
    int              start_cyc;
  } exp4_t;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  logic              start8, sm8, busy8, done8;
  logic [W8-1:0]     a8, b8;
  logic [2*W8-1:0]   prod8;
  logic              start4, sm4, busy4, done4;
  logic [W4-1:0]     a4, b4;
  logic [2*W4-1:0]   prod4;

  shift_add_multiplier #(.WIDTH(W8), .SIGNED_EN(1'b1)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .START(start8), .SIGNED_MODE(sm8),
    .A(a8), .B(b8), .BUSY(busy8), .DONE(done8), .MULT_SAIDA(prod8)
  );

  shift_add_multiplier #(.WIDTH(W4), .SIGNED_EN(1'b0)) dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .START(start4), .SIGNED_MODE(sm4),
    .A(a4), .B(b4), .BUSY(busy4), .DONE(done4), .MULT_SAIDA(prod4)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  exp8_t q8[$];
  exp4_t q4[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer multiplication, truncated to the product width.
  function automatic logic [2*W8-1:0] model8(input logic [W8-1:0] a, input logic [W8-1:0] b,
                                             input logic sm);
    longint p;
    if (sm) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'(a) * longint'(b);
    return p[2*W8-1:0];
  endfunction

  function automatic logic [2*W4-1:0] model4(input logic [W4-1:0] a, input logic [W4-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[2*W4-1:0];
  endfunction

  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      if (done8) begin
        if (q8.size() == 0) begin
          check("unexpected_done8", 32'(done8), 32'd0);
        end else begin
          exp8_t e;
          e = q8.pop_front();
          check("prod8", 32'(prod8), 32'(e.prod));
          check("latency8", 32'(cyc - e.start_cyc), 32'(W8));
          check("busy8_at_done", 32'(busy8), 32'd0);
        end
      end
      if (done4) begin
        if (q4.size() == 0) begin
          check("unexpected_done4", 32'(done4), 32'd0);
        end else begin
          exp4_t e;
          e = q4.pop_front();
          check("prod4", 32'(prod4), 32'(e.prod));
          check("latency4", 32'(cyc - e.start_cyc), 32'(W4));
        end
      end
    end
  end

  // All drive tasks assume they are entered shortly after a rising edge with the DUT idle.
  task automatic issue8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic sm);
    exp8_t e;
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge CLK); #1;
    e.prod = model8(a, b, sm);
    e.start_cyc = cyc;
    q8.push_back(e);
    start8 = 1'b0;
    a8 = W8'($urandom); b8 = W8'($urandom); sm8 = 1'($urandom);
  endtask

  task automatic issue4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic sm);
    exp4_t e;
    a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
    @(posedge CLK); #1;
    e.prod = model4(a, b);
    e.start_cyc = cyc;
    q4.push_back(e);
    start4 = 1'b0;
    a4 = W4'($urandom); b4 = W4'($urandom); sm4 = 1'($urandom);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 40) begin
      @(posedge CLK);
      n++;
    end
    check("drain8_timeout", 32'(q8.size()), 32'd0);
    q8.delete();
    #1;
  endtask

  task automatic drain4();
    int n = 0;
    while (q4.size() != 0 && n < 40) begin
      @(posedge CLK);
      n++;
    end
    check("drain4_timeout", 32'(q4.size()), 32'd0);
    q4.delete();
    #1;
  endtask

  initial begin
    exp8_t e;
    int s;
    RESET_N = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;

    // Reset held for 100 ns with random inputs, outputs must stay clear.
    repeat (10) begin
      #10;
      start8 = 1'($urandom); sm8 = 1'($urandom); a8 = W8'($urandom); b8 = W8'($urandom);
      start4 = 1'($urandom); a4 = W4'($urandom); b4 = W4'($urandom);
      #1;
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_prod8", 32'(prod8), 32'd0);
      check("rst_prod4", 32'(prod4), 32'd0);
    end
    start8 = 1'b0; start4 = 1'b0;
    @(posedge CLK); #2;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    check("idle_busy8", 32'(busy8), 32'd0);

    issue8(8'd5, 8'd4, 1'b0);     drain8();
    check("five_times_four", 32'(prod8), 32'd20);
    issue8(8'd255, 8'd255, 1'b0); drain8();
    check("max_unsigned", 32'(prod8), 32'hFE01);
    issue8(8'hFD, 8'd5, 1'b1);    drain8();
    check("neg3_times_5", 32'(prod8), 32'hFFF1);
    issue8(8'h80, 8'h80, 1'b1);   drain8();
    check("min_times_min_signed", 32'(prod8), 32'h4000);
    issue8(8'h80, 8'h80, 1'b0);   drain8();
    check("x80_times_x80_unsigned", 32'(prod8), 32'h4000);
    issue8(8'h00, 8'h9C, 1'b1);   drain8();
    check("zero_times_neg", 32'(prod8), 32'h0000);
    issue8(8'h80, 8'd1, 1'b1);    drain8();
    check("min_times_one", 32'(prod8), 32'hFF80);

    // START held high; operands churn during CALC, second op captured at first IDLE.
    a8 = 8'd7; b8 = 8'd6; sm8 = 1'b0; start8 = 1'b1;
    @(posedge CLK); #1;
    s = cyc;
    e.prod = model8(8'd7, 8'd6, 1'b0); e.start_cyc = s;
    q8.push_back(e);
    for (int k = 1; k <= W8 + 1; k++) begin
      @(posedge CLK); #1;
      if (k <= W8) begin
        a8 = W8'($urandom); b8 = W8'($urandom); sm8 = 1'($urandom);
      end else begin
        a8 = 8'd3; b8 = 8'd11; sm8 = 1'b0;
        e.prod = model8(8'd3, 8'd11, 1'b0); e.start_cyc = s + W8 + 2;
        q8.push_back(e);
      end
    end
    @(posedge CLK); #1;
    start8 = 1'b0;
    drain8();
    check("held_start_second", 32'(prod8), 32'd33);

    // Asynchronous reset mid-cycle during iteration 3 aborts the operation.
    issue8(8'd9, 8'd9, 1'b0);
    repeat (3) @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    q8.delete();
    #1;
    check("abort_prod8", 32'(prod8), 32'd0);
    check("abort_busy8", 32'(busy8), 32'd0);
    check("abort_done8", 32'(done8), 32'd0);
    @(posedge CLK); #2;
    RESET_N = 1'b1;
    repeat (W8 + 4) @(posedge CLK);
    #1;
    check("abort_prod8_later", 32'(prod8), 32'd0);
    issue8(8'd9, 8'd9, 1'b0);     drain8();
    check("nine_squared", 32'(prod8), 32'd81);

    for (int i = 0; i < 40; i++) begin
      issue8(W8'($urandom), W8'($urandom), 1'($urandom));
      drain8();
    end

    // 4-bit instance with signed support compiled out.
    issue4(4'd15, 4'd15, 1'b1);   drain4();
    check("w4_max", 32'(prod4), 32'hE1);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue4(W4'(a), W4'(b), 1'($urandom));
        drain4();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
